apb4_ahb3_bridge: RTL and testbench
===================================

APB4_AHB3_BRIDGE -- requirements
Module: apb4_ahb3_bridge

Interface
REQ-001 SHALL have parameter PADDR_SIZE, default 16, APB4 address width.
REQ-002 SHALL have parameter HADDR_SIZE, default 32, AHB3-lite address width.
REQ-003 SHALL have parameter AHB_BASE, default 32'h4000_0000, AHB window base; HADDR = AHB_BASE[HADDR_SIZE-1:PADDR_SIZE] concatenated with the translated PADDR.
REQ-004 SHALL have one clock and a synchronous, active-high reset: CLK in 1, rising-edge clock; RESET in 1, synchronous active-high reset.
REQ-005 SHALL have APB4 slave ports: PSEL in 1; PENABLE in 1; PWRITE in 1; PPROT in 3; PSTRB in 4; PADDR in PADDR_SIZE; PWDATA in 32; PRDATA out 32; PREADY out 1; PSLVERR out 1.
REQ-006 SHALL have AHB3-lite master ports: HADDR out HADDR_SIZE; HWDATA out 32; HRDATA in 32; HWRITE out 1; HSIZE out 3; HBURST out 3; HPROT out 4; HTRANS out 2; HMASTLOCK out 1; HREADY in 1; HRESP in 1.

Function
REQ-007 SHALL implement FSM states IDLE, ADDR, DATA, RESP; one APB access maps to at most one AHB SINGLE transfer.
REQ-008 IDLE: when PSEL=1 and PENABLE=0, SHALL latch PWRITE, PADDR, PWDATA, PSTRB, PPROT and go to ADDR; if the strobe pattern is illegal (REQ-011), SHALL go to RESP with an error instead.
REQ-009 ADDR: SHALL drive HTRANS=NONSEQ (2'b10), HBURST=3'b000, HMASTLOCK=0, plus HADDR, HWRITE, HSIZE and HPROT from the latched values; stays in ADDR while HREADY=0, moves to DATA on HREADY=1.
REQ-010 DATA: SHALL drive HTRANS=IDLE and HWDATA=latched PWDATA, unchanged (lanes already positioned); on HREADY=1, SHALL capture HRDATA to PRDATA and HRESP to an error flag, then go to RESP.
REQ-011 Write size decode from PSTRB: 4'b1111 -> HSIZE word, HADDR[1:0]=00; 4'b0011/4'b1100 -> halfword, [1:0]=00/10; one-hot -> byte, [1:0]=index of the set bit; any other pattern, including 4'b0000, is illegal: no AHB transfer, PSLVERR=1.
REQ-012 Reads SHALL ignore PSTRB and use HSIZE=word with HADDR[1:0]=00.
REQ-013 HPROT SHALL be {2'b00, PPROT[0], ~PPROT[2]}.
REQ-014 RESP: SHALL assert PREADY=1 for exactly one cycle, with PSLVERR = error flag and PRDATA valid for reads (0 for writes and errors); SHALL then return to IDLE.
REQ-015 PREADY SHALL be 0 in every state except RESP.
REQ-016 An HRESP=1 in the first error cycle (HREADY=0) SHALL be held; the FSM leaves DATA only on the HREADY=1 cycle, and HTRANS stays IDLE throughout.
REQ-017 Latency SHALL be setup cycle + 1 (ADDR) + 1 (DATA) + 1 (RESP) with zero AHB wait states; each HREADY=0 cycle adds one cycle.
REQ-018 PSEL=1 with PENABLE=1 in IDLE (protocol violation) SHALL be ignored; no transfer starts.

Reset
REQ-019 While RESET=1 at a clock edge: FSM=IDLE; HTRANS=IDLE; HADDR=0; HWRITE=0; HSIZE=0; HPROT=0; HWDATA=0; PRDATA=0; PREADY=0; PSLVERR=0; HBURST and HMASTLOCK stay 0.
REQ-020 RESET asserted in ADDR or DATA SHALL abandon the transfer at the next edge with no PREADY pulse; HTRANS=IDLE from that edge.

Verification
REQ-021 Word write: PADDR=16'h0010, PSTRB=4'hF, PWDATA=32'hDEADBEEF, HREADY=1 -> HADDR=32'h4000_0010, HSIZE=2, HWRITE=1, NONSEQ for one cycle; HWDATA=DEADBEEF next cycle; PREADY=1, PSLVERR=0 on the 4th cycle after setup.
REQ-022 Byte write: PSTRB=4'b0100, PADDR=16'h0020 -> HADDR=32'h4000_0022, HSIZE=0, HWDATA=PWDATA unchanged.
REQ-023 Read with 3 wait states: HRDATA=32'h12345678 on the HREADY=1 cycle -> PRDATA=12345678, PREADY pulse delayed by exactly 3 cycles, HSIZE=2 with PSTRB=4'h0.
REQ-024 AHB error: HRESP=1/HREADY=0 then HRESP=1/HREADY=1 in DATA -> PSLVERR=1 with PREADY=1, PRDATA=0, HTRANS=IDLE both cycles.
REQ-025 Illegal strobe 4'b0101 write -> HTRANS stays IDLE the whole access; PREADY=1, PSLVERR=1 one cycle after setup+1.
REQ-026 RESET=1 during DATA with HREADY=0 -> next edge: all outputs at reset values, no PREADY; a following legal access completes normally.

Source files
------------

// File: rtl/apb4_ahb3_bridge.sv
// APB4 slave to AHB3-lite master bridge: each APB access becomes at most one AHB SINGLE transfer.
// Write size and HADDR[1:0] are derived from PSTRB; illegal strobe patterns answer with PSLVERR.
module apb4_ahb3_bridge #(
  parameter int unsigned PADDR_SIZE = 16,
  parameter int unsigned HADDR_SIZE = 32,
  parameter logic [HADDR_SIZE-1:0] AHB_BASE = 32'h4000_0000
) (
  input  logic                  CLK,
  input  logic                  RESET,
  // APB4 slave
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [2:0]            PPROT,
  input  logic [3:0]            PSTRB,
  input  logic [PADDR_SIZE-1:0] PADDR,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  // AHB3-lite master
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [31:0]           HWDATA,
  input  logic [31:0]           HRDATA,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_t;

  state_t      state_q;
  logic [31:0] pwdata_q;
  logic        err_q;

  logic [2:0]  size;
  logic [1:0]  addr_lo;
  logic        strb_legal;
  logic        unused_bits;

  assign HBURST      = 3'b000;
  assign HMASTLOCK   = 1'b0;
  assign unused_bits = ^{PPROT[1], PADDR[1:0]};

  // Reads always move a full word; writes size themselves from the byte strobes.
  always_comb begin
    size       = 3'd2;
    addr_lo    = 2'b00;
    strb_legal = 1'b1;
    if (PWRITE) begin
      case (PSTRB)
        4'b1111: ;
        4'b0011: size = 3'd1;
        4'b1100: begin size = 3'd1; addr_lo = 2'b10; end
        4'b0001: begin size = 3'd0; addr_lo = 2'b00; end
        4'b0010: begin size = 3'd0; addr_lo = 2'b01; end
        4'b0100: begin size = 3'd0; addr_lo = 2'b10; end
        4'b1000: begin size = 3'd0; addr_lo = 2'b11; end
        default: strb_legal = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= StIdle;
      HTRANS   <= TransIdle;
      HADDR    <= '0;
      HWRITE   <= 1'b0;
      HSIZE    <= 3'd0;
      HPROT    <= 4'd0;
      HWDATA   <= 32'd0;
      PRDATA   <= 32'd0;
      PREADY   <= 1'b0;
      PSLVERR  <= 1'b0;
      pwdata_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= 32'd0;
          // Only a genuine setup phase starts a transfer; PSEL with PENABLE here is ignored.
          if (PSEL && !PENABLE) begin
            HWRITE   <= PWRITE;
            HADDR    <= {AHB_BASE[HADDR_SIZE-1:PADDR_SIZE], PADDR[PADDR_SIZE-1:2], addr_lo};
            HSIZE    <= size;
            HPROT    <= {2'b00, PPROT[0], ~PPROT[2]};
            pwdata_q <= PWDATA;
            err_q    <= 1'b0;
            if (strb_legal) begin
              HTRANS  <= TransNonseq;
              state_q <= StAddr;
            end else begin
              PREADY  <= 1'b1;
              PSLVERR <= 1'b1;
              state_q <= StResp;
            end
          end
        end
        StAddr: begin
          if (HREADY) begin
            HTRANS  <= TransIdle;
            HWDATA  <= pwdata_q;
            state_q <= StData;
          end
        end
        StData: begin
          // An error seen in the first (wait) cycle of a two-cycle response must stick.
          err_q <= err_q | HRESP;
          if (HREADY) begin
            PREADY  <= 1'b1;
            PSLVERR <= err_q | HRESP;
            PRDATA  <= (!HWRITE && !(err_q | HRESP)) ? HRDATA : 32'd0;
            state_q <= StResp;
          end
        end
        StResp: begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= 32'd0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_ahb3_bridge.sv
// Directed bench for apb4_ahb3_bridge: inputs change and outputs are sampled on the falling edge.
module tb_apb4_ahb3_bridge;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        PSEL, PENABLE, PWRITE;
  logic [2:0]  PPROT;
  logic [3:0]  PSTRB;
  logic [15:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK, HREADY, HRESP;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  apb4_ahb3_bridge dut (
    .CLK(CLK), .RESET(RESET),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PPROT(PPROT), .PSTRB(PSTRB),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  task automatic apb_setup(input logic wr, input logic [15:0] addr, input logic [3:0] strb,
                           input logic [31:0] data, input logic [2:0] prot);
    @(negedge CLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PSTRB = strb;
    PWDATA = data; PPROT = prot; HREADY = 1'b1; HRESP = 1'b0;
  endtask

  task automatic test_reset;
    logic [95:0] obs;
    RESET = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PPROT = 0; PSTRB = 0; PADDR = 0;
    PWDATA = 0; HRDATA = 0; HREADY = 1; HRESP = 0;
    @(negedge CLK); @(negedge CLK);
    obs = {HTRANS, HADDR, HWRITE, HSIZE, HPROT, HWDATA, PREADY, PSLVERR, HBURST, HMASTLOCK};
    total++;
    if (obs !== 96'd0) begin
      bad++; $display("FAIL reset_ahb: got %h want 0", obs);
    end
    total++;
    if (PRDATA !== 32'd0) begin
      bad++; $display("FAIL reset_prdata: got %h want 0", PRDATA);
    end
    RESET = 1'b0;
  endtask

  task automatic test_word_write;
    apb_setup(1'b1, 16'h0010, 4'hF, 32'hDEADBEEF, 3'b000);
    @(negedge CLK);
    total++;
    if ({HTRANS, HADDR, HSIZE, HWRITE, HPROT, HBURST, HMASTLOCK, PREADY} !==
        {2'b10, 32'h4000_0010, 3'd2, 1'b1, 4'b0001, 3'b000, 1'b0, 1'b0}) begin
      bad++; $display("FAIL word_addr: trans=%b haddr=%h size=%0d write=%b prot=%b pready=%b",
                      HTRANS, HADDR, HSIZE, HWRITE, HPROT, PREADY);
    end
    PENABLE = 1'b1;
    @(negedge CLK);
    total++;
    if ({HTRANS, HWDATA, PREADY} !== {2'b00, 32'hDEADBEEF, 1'b0}) begin
      bad++; $display("FAIL word_data: trans=%b hwdata=%h pready=%b want 00 deadbeef 0",
                      HTRANS, HWDATA, PREADY);
    end
    @(negedge CLK);
    total++;
    if ({PREADY, PSLVERR, PRDATA} !== {1'b1, 1'b0, 32'd0}) begin
      bad++; $display("FAIL word_resp: pready=%b pslverr=%b prdata=%h want 1 0 0",
                      PREADY, PSLVERR, PRDATA);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge CLK);
    total++;
    if ({PREADY, HTRANS} !== 3'b000) begin
      bad++; $display("FAIL word_pready_one_cycle: pready=%b trans=%b want 0 00", PREADY, HTRANS);
    end
  endtask

  task automatic test_byte_write;
    apb_setup(1'b1, 16'h0020, 4'b0100, 32'h11223344, 3'b101);
    @(negedge CLK);
    total++;
    if ({HTRANS, HADDR, HSIZE, HWRITE, HPROT} !== {2'b10, 32'h4000_0022, 3'd0, 1'b1, 4'b0010})
    begin
      bad++; $display("FAIL byte_addr: trans=%b haddr=%h size=%0d write=%b prot=%b",
                      HTRANS, HADDR, HSIZE, HWRITE, HPROT);
    end
    PENABLE = 1'b1;
    @(negedge CLK);
    total++;
    if (HWDATA !== 32'h11223344) begin
      bad++; $display("FAIL byte_hwdata: got %h want 11223344", HWDATA);
    end
    @(negedge CLK);
    total++;
    if ({PREADY, PSLVERR} !== 2'b10) begin
      bad++; $display("FAIL byte_resp: pready=%b pslverr=%b want 1 0", PREADY, PSLVERR);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_halfword_write;
    int i;
    apb_setup(1'b1, 16'h0040, 4'b1100, 32'hA5A5_0000, 3'b000);
    @(negedge CLK);
    total++;
    if ({HTRANS, HADDR, HSIZE} !== {2'b10, 32'h4000_0042, 3'd1}) begin
      bad++; $display("FAIL half_addr: trans=%b haddr=%h size=%0d want 10 40000042 1",
                      HTRANS, HADDR, HSIZE);
    end
    PENABLE = 1'b1;
    for (i = 0; i < 10 && !PREADY; i++) @(negedge CLK);
    total++;
    if ({PREADY, PSLVERR} !== 2'b10) begin
      bad++; $display("FAIL half_resp: pready=%b pslverr=%b want 1 0", PREADY, PSLVERR);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_read_wait;
    int c;
    logic trans_ok;
    trans_ok = 1'b1;
    HRDATA = 32'hBAD0BAD0;
    apb_setup(1'b0, 16'h0032, 4'h0, 32'h0, 3'b001);
    @(negedge CLK);
    total++;
    if ({HTRANS, HADDR, HSIZE, HWRITE, HPROT} !== {2'b10, 32'h4000_0030, 3'd2, 1'b0, 4'b0011})
    begin
      bad++; $display("FAIL read_addr: trans=%b haddr=%h size=%0d write=%b prot=%b",
                      HTRANS, HADDR, HSIZE, HWRITE, HPROT);
    end
    PENABLE = 1'b1;
    for (c = 2; c <= 12; c++) begin
      @(negedge CLK);
      if (PREADY) break;
      if (HTRANS !== 2'b00) trans_ok = 1'b0;
      HREADY = (c == 5);
      HRDATA = (c == 5) ? 32'h12345678 : 32'hBAD0BAD0;
    end
    total++;
    if (c !== 6) begin
      bad++; $display("FAIL read_latency: pready at cycle %0d want 6", c);
    end
    total++;
    if ({PREADY, PSLVERR, PRDATA, trans_ok} !== {1'b1, 1'b0, 32'h12345678, 1'b1}) begin
      bad++; $display("FAIL read_resp: pready=%b pslverr=%b prdata=%h trans_idle=%b",
                      PREADY, PSLVERR, PRDATA, trans_ok);
    end
    PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1;
  endtask

  task automatic test_ahb_error;
    apb_setup(1'b1, 16'h0050, 4'hF, 32'h0BADF00D, 3'b000);
    @(negedge CLK);
    PENABLE = 1'b1;
    @(negedge CLK);
    HRESP = 1'b1; HREADY = 1'b0;
    @(negedge CLK);
    total++;
    if ({HTRANS, PREADY} !== 3'b000) begin
      bad++; $display("FAIL err_first_cycle: trans=%b pready=%b want 00 0", HTRANS, PREADY);
    end
    HRESP = 1'b1; HREADY = 1'b1;
    @(negedge CLK);
    total++;
    if ({PREADY, PSLVERR, PRDATA, HTRANS} !== {1'b1, 1'b1, 32'd0, 2'b00}) begin
      bad++; $display("FAIL err_resp: pready=%b pslverr=%b prdata=%h trans=%b",
                      PREADY, PSLVERR, PRDATA, HTRANS);
    end
    HRESP = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_error_held;
    HRDATA = 32'hAAAA5555;
    apb_setup(1'b0, 16'h0054, 4'h0, 32'h0, 3'b000);
    @(negedge CLK);
    PENABLE = 1'b1;
    @(negedge CLK);
    HRESP = 1'b1; HREADY = 1'b0;
    @(negedge CLK);
    HRESP = 1'b0; HREADY = 1'b1;
    @(negedge CLK);
    total++;
    if ({PREADY, PSLVERR, PRDATA} !== {1'b1, 1'b1, 32'd0}) begin
      bad++; $display("FAIL err_held: pready=%b pslverr=%b prdata=%h want 1 1 0",
                      PREADY, PSLVERR, PRDATA);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_illegal_strobe(input logic [3:0] strb);
    apb_setup(1'b1, 16'h0060, strb, 32'h55555555, 3'b000);
    @(negedge CLK);
    total++;
    if ({PREADY, PSLVERR, HTRANS, PRDATA} !== {1'b1, 1'b1, 2'b00, 32'd0}) begin
      bad++; $display("FAIL illegal_%b: pready=%b pslverr=%b trans=%b prdata=%h",
                      strb, PREADY, PSLVERR, HTRANS, PRDATA);
    end
    PENABLE = 1'b1;
    @(negedge CLK);
    total++;
    if ({PREADY, PSLVERR, HTRANS} !== 4'b0000) begin
      bad++; $display("FAIL illegal_after_%b: pready=%b pslverr=%b trans=%b want 0 0 00",
                      strb, PREADY, PSLVERR, HTRANS);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_protocol_violation;
    logic quiet;
    quiet = 1'b1;
    @(negedge CLK);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PSTRB = 4'hF; PADDR = 16'h0080;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (HTRANS !== 2'b00 || PREADY !== 1'b0) quiet = 1'b0;
    end
    total++;
    if (quiet !== 1'b1) begin
      bad++; $display("FAIL penable_in_idle: transfer started (trans=%b pready=%b)",
                      HTRANS, PREADY);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_back_to_back;
    HRDATA = 32'h01010101;
    apb_setup(1'b0, 16'h0100, 4'h0, 32'h0, 3'b000);
    @(negedge CLK);
    PENABLE = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    total++;
    if ({PREADY, PRDATA} !== {1'b1, 32'h01010101}) begin
      bad++; $display("FAIL b2b_first: pready=%b prdata=%h want 1 01010101", PREADY, PRDATA);
    end
    @(negedge CLK);
    total++;
    if (PREADY !== 1'b0) begin
      bad++; $display("FAIL b2b_gap: pready=%b want 0", PREADY);
    end
    PENABLE = 1'b0; PADDR = 16'h0104; HRDATA = 32'h02020202;
    @(negedge CLK);
    total++;
    if ({HTRANS, HADDR} !== {2'b10, 32'h4000_0104}) begin
      bad++; $display("FAIL b2b_second_addr: trans=%b haddr=%h want 10 40000104", HTRANS, HADDR);
    end
    PENABLE = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    total++;
    if ({PREADY, PRDATA} !== {1'b1, 32'h02020202}) begin
      bad++; $display("FAIL b2b_second: pready=%b prdata=%h want 1 02020202", PREADY, PRDATA);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset_in_data;
    logic [95:0] obs;
    int i;
    apb_setup(1'b1, 16'h0060, 4'hF, 32'hCAFEF00D, 3'b000);
    @(negedge CLK);
    PENABLE = 1'b1;
    @(negedge CLK);
    HREADY = 1'b0; RESET = 1'b1;
    @(negedge CLK);
    obs = {HTRANS, HADDR, HWRITE, HSIZE, HPROT, HWDATA, PREADY, PSLVERR, HBURST, HMASTLOCK};
    total++;
    if ({obs, PRDATA} !== 128'd0) begin
      bad++; $display("FAIL reset_in_data: outputs %h prdata %h want 0", obs, PRDATA);
    end
    RESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; HREADY = 1'b1;
    @(negedge CLK);
    total++;
    if ({PREADY, HTRANS} !== 3'b000) begin
      bad++; $display("FAIL reset_no_pready: pready=%b trans=%b want 0 00", PREADY, HTRANS);
    end
    apb_setup(1'b1, 16'h0070, 4'b1000, 32'h77000000, 3'b000);
    @(negedge CLK);
    total++;
    if ({HTRANS, HADDR, HSIZE} !== {2'b10, 32'h4000_0073, 3'd0}) begin
      bad++; $display("FAIL post_reset_addr: trans=%b haddr=%h size=%0d", HTRANS, HADDR, HSIZE);
    end
    PENABLE = 1'b1;
    for (i = 0; i < 10 && !PREADY; i++) @(negedge CLK);
    total++;
    if ({PREADY, PSLVERR, HWDATA} !== {1'b1, 1'b0, 32'h77000000}) begin
      bad++; $display("FAIL post_reset_resp: pready=%b pslverr=%b hwdata=%h",
                      PREADY, PSLVERR, HWDATA);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_byte_write();
    test_halfword_write();
    test_read_wait();
    test_ahb_error();
    test_error_held();
    test_illegal_strobe(4'b0101);
    test_illegal_strobe(4'b0000);
    test_protocol_violation();
    test_back_to_back();
    test_reset_in_data();
    @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
